if_prefetch_stage: RTL

//  Parametrised instruction-fetch stage with a DEPTH-entry prefetch FIFO.

---
 rtl/if_prefetch_stage_if.sv | 14 +
 rtl/if_prefetch_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage_if.sv
// Single-outstanding read port between the fetch stage (master) and instruction memory (slave).
// Strobe and ready are active-low; the address is held until ready completes the read.
interface if_prefetch_stage_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_as_;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rdy_;

  modport master (output mem_addr, mem_as_, input mem_rd_data, mem_rdy_);
  modport slave  (input mem_addr, mem_as_, output mem_rd_data, mem_rdy_);
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: prefetches sequential words into a DEPTH-entry FIFO
// and feeds the IF/ID register; flush/branch redirects discard prefetched words.
module if_prefetch_stage #(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  if_prefetch_stage_if.master mem,
  input  logic                stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   new_pc,
  input  logic                br_taken,
  input  logic [ADDR_W-1:0]   br_addr,
  output logic                busy,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [DATA_W-1:0]   if_insn,
  output logic                if_en
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fpc, fpc_nxt, tgt, tgt_nxt, target;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] insn_q [DEPTH];
  logic              strobe, completed, redirect, push, pop;

  always_comb begin
    // Strobe is gated by reset so the port is idle while reset is held.
    strobe    = reset & ((state == S_DROP) | (count < CNT_W'(DEPTH)));
    completed = strobe & ~mem.mem_rdy_;
    redirect  = flush | (br_taken & ~stall);
    target    = flush ? new_pc : br_addr;
    push      = completed & ~redirect & (state == S_FETCH);
    pop       = ~flush & ~stall & ~br_taken & (count != '0);
    busy      = (count == '0) & strobe & (state == S_FETCH);
    mem.mem_as_  = ~strobe;
    mem.mem_addr = fpc;

    state_nxt = state;
    fpc_nxt   = fpc;
    tgt_nxt   = tgt;
    if (redirect) begin
      if (!strobe || completed) begin
        fpc_nxt   = target;
        state_nxt = S_FETCH;
      end else begin
        // Read cannot be aborted: remember the target and swallow its data.
        tgt_nxt   = target;
        state_nxt = S_DROP;
      end
    end else if (state == S_DROP) begin
      if (completed) begin
        fpc_nxt   = tgt;
        state_nxt = S_FETCH;
      end
    end else if (push) begin
      fpc_nxt = fpc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      fpc   <= RESET_PC;
      tgt   <= RESET_PC;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= fpc;
      insn_q[wr_ptr] <= mem.mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_en   <= 1'b0;
      if_pc   <= RESET_PC;
      if_insn <= '0;
    end else if (flush) begin
      if_en <= 1'b0;
    end else if (!stall) begin
      if (br_taken) begin
        if_en <= 1'b0;
      end else if (pop) begin
        if_en   <= 1'b1;
        if_pc   <= pc_q[rd_ptr];
        if_insn <= insn_q[rd_ptr];
      end else begin
        if_en <= 1'b0;
      end
    end
  end
endmodule
